// File: rtl/serial_txrx_link.sv
// serial_txrx_link: loopback serial link sharing one clock.
// The transmitter frames a DATA_W-bit word as start(1), LSB-first data and stop(0).
// The receiver deserializes the frame, holds the last word, and offers it under
// an RX_Ready / RX_Data_Valid handshake. The line is exported as S_Data.
module serial_txrx_link #(
  parameter int DATA_W = 55,
  parameter int CNT_W  = 6
) (
  input  logic              Clk_S,
  input  logic              Rst,
  input  logic [DATA_W-1:0] TX_Data,
  input  logic              TX_Data_Valid,
  output logic              TX_Ready,
  input  logic              RX_Ready,
  output logic              RX_Data_Valid,
  output logic [DATA_W-1:0] RX_Data,
  output logic              S_Data
);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_LOAD = 2'd2
  } rx_state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // transmitter state
  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_ready_q, tx_ready_d;
  logic              s_data_q, s_data_d;
  logic              tv_q, tv_d;

  // receiver state
  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_vld_q, rx_vld_d;

  logic tx_start;
  logic rx_bit;

  // A start needs a fresh rising edge of TX_Data_Valid while idle; a level
  // held high across reset or a previous frame is therefore ignored.
  assign tx_start = (tx_state_q == TX_IDLE) && TX_Data_Valid && !tv_q;

  // The receiver samples the registered line, exactly what leaves the block.
  assign rx_bit = s_data_q;

  // State register for both FSMs and all datapath flops.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_ready_q <= 1'b0;
      s_data_q   <= 1'b0;
      tv_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_full_q  <= 1'b0;
      rx_vld_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_ready_q <= tx_ready_d;
      s_data_q   <= s_data_d;
      tv_q       <= tv_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

  // Transmitter next-state: IDLE -> START -> DATA x DATA_W -> STOP -> IDLE.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (tx_start) tx_state_d = TX_START;
      TX_START: tx_state_d = TX_DATA;
      TX_DATA:  if (tx_cnt_q == LAST_BIT) tx_state_d = TX_STOP;
      TX_STOP:  tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // Transmitter outputs/datapath: line level and ready are computed from the
  // current state and registered, so each appears one edge after the state.
  always_comb begin
    tx_cnt_d   = tx_cnt_q;
    tx_sh_d    = tx_sh_q;
    tx_ready_d = 1'b0;
    s_data_d   = 1'b0;
    tv_d       = TX_Data_Valid;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d   = '0;
        tx_ready_d = !tx_start;
        if (tx_start) tx_sh_d = TX_Data;
      end
      TX_START: begin
        s_data_d = 1'b1;
        tx_cnt_d = '0;
      end
      TX_DATA: begin
        s_data_d = tx_sh_q[0];
        tx_sh_d  = tx_sh_q >> 1;
        tx_cnt_d = (tx_cnt_q == LAST_BIT) ? '0 : tx_cnt_q + CNT_W'(1);
      end
      TX_STOP: begin
        s_data_d = 1'b0;
      end
      default: begin
        tx_cnt_d = '0;
      end
    endcase
  end

  // Receiver next-state: a sampled 1 while idle is a start bit; after DATA_W
  // data bits a single LOAD cycle publishes the word. The stop bit falls into
  // LOAD and is not examined.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (rx_bit) rx_state_d = RX_RECV;
      RX_RECV: if (rx_cnt_q == LAST_BIT) rx_state_d = RX_LOAD;
      RX_LOAD: rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver datapath and consumer handshake.
  always_comb begin
    rx_cnt_d  = rx_cnt_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_full_d = rx_full_q;
    rx_vld_d  = rx_vld_q;
    case (rx_state_q)
      RX_IDLE: rx_cnt_d = '0;
      RX_RECV: begin
        // LSB arrives first, so shift in from the top.
        rx_sh_d  = {rx_bit, rx_sh_q[DATA_W-1:1]};
        rx_cnt_d = (rx_cnt_q == LAST_BIT) ? '0 : rx_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase

    if (rx_vld_q) begin
      if (!RX_Ready) begin
        rx_vld_d  = 1'b0;
        rx_full_d = 1'b0;
      end
    end else if (rx_full_q && RX_Ready) begin
      rx_vld_d = 1'b1;
    end

    // A freshly loaded word must not be lost to a handshake retiring the old
    // one on the same edge, so LOAD wins over the clear.
    if (rx_state_q == RX_LOAD) begin
      rx_data_d = rx_sh_q;
      rx_full_d = 1'b1;
    end
  end

  assign TX_Ready      = tx_ready_q;
  assign S_Data        = s_data_q;
  assign RX_Data       = rx_data_q;
  assign RX_Data_Valid = rx_vld_q;

endmodule

// File: tb/tb_serial_txrx_link.sv
// Bench for serial_txrx_link: random words and the directed patterns, with the
// expected line waveform and receiver contents derived from the frame format.
module tb_serial_txrx_link;
  localparam int DW = 55;

  logic          Clk_S = 1'b0;
  logic          Rst = 1'b1;
  logic [DW-1:0] TX_Data = '0;
  logic          TX_Data_Valid = 1'b0;
  logic          TX_Ready;
  logic          RX_Ready = 1'b0;
  logic          RX_Data_Valid;
  logic [DW-1:0] RX_Data;
  logic          S_Data;

  int total = 0;
  int bad = 0;

  // receiver reference: last word delivered and whether it is still unconsumed
  logic [DW-1:0] model_word = '0;
  bit            model_full = 1'b0;

  localparam logic [DW-1:0] PATTERN =
    55'b101101110_1110001110_101101110_1110001110_101101110_11101;

  serial_txrx_link #(.DATA_W(DW), .CNT_W(6)) dut (
    .Clk_S(Clk_S), .Rst(Rst), .TX_Data(TX_Data), .TX_Data_Valid(TX_Data_Valid),
    .TX_Ready(TX_Ready), .RX_Ready(RX_Ready), .RX_Data_Valid(RX_Data_Valid),
    .RX_Data(RX_Data), .S_Data(S_Data)
  );

  always #5 Clk_S = ~Clk_S;

  task automatic tick();
    @(posedge Clk_S);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Start a frame with a fresh valid edge and check the full line waveform.
  task automatic send_frame(input logic [DW-1:0] w, input bit hold, input bit noise,
                            input bit check_rx);
    logic [DW+1:0] line;
    line = {1'b0, w, 1'b1};  // index 0 is the start bit, then LSB-first data, then stop
    TX_Data = w;
    TX_Data_Valid = 1'b1;
    tick();  // start edge k
    total++;
    if (TX_Ready !== 1'b0) begin
      bad++; $display("FAIL tx_ready_drop got=%b want=0", TX_Ready);
    end
    TX_Data = rand_word();  // must not disturb the latched word
    for (int n = 0; n < DW + 2; n++) begin
      if (!hold) begin
        if (n == 3) TX_Data_Valid = 1'b0;
        else if (noise && n > 3 && n < DW - 4) TX_Data_Valid = 1'($urandom_range(0, 1));
        else if (n >= DW - 4) TX_Data_Valid = 1'b0;
      end
      tick();  // edge k+1+n
      total++;
      if (S_Data !== line[n]) begin
        bad++; $display("FAIL s_data slot=%0d got=%b want=%b", n, S_Data, line[n]);
      end
      total++;
      if (TX_Ready !== 1'b0) begin
        bad++; $display("FAIL tx_ready_busy slot=%0d got=%b want=0", n, TX_Ready);
      end
    end
    tick();  // edge k+58
    total++;
    if (TX_Ready !== 1'b1) begin
      bad++; $display("FAIL tx_ready_return got=%b want=1", TX_Ready);
    end
    if (check_rx) begin
      tick();
      tick();
      total++;
      if (RX_Data !== w) begin
        bad++; $display("FAIL rx_data got=%h want=%h", RX_Data, w);
      end
    end
  endtask

  // Consumer handshake against the receiver reference.
  task automatic consume();
    RX_Ready = 1'b1;
    tick();
    total++;
    if (RX_Data_Valid !== model_full) begin
      bad++; $display("FAIL rx_valid_rise got=%b want=%b", RX_Data_Valid, model_full);
    end
    repeat (3) begin
      tick();
      total++;
      if (RX_Data_Valid !== model_full || RX_Data !== model_word) begin
        bad++; $display("FAIL rx_valid_hold valid=%b data=%h want=%b/%h",
                        RX_Data_Valid, RX_Data, model_full, model_word);
      end
    end
    RX_Ready = 1'b0;
    tick();
    total++;
    if (RX_Data_Valid !== 1'b0) begin
      bad++; $display("FAIL rx_valid_clear got=%b want=0", RX_Data_Valid);
    end
    model_full = 1'b0;
    // word was retired: asking again must not re-present it
    RX_Ready = 1'b1;
    tick();
    total++;
    if (RX_Data_Valid !== 1'b0) begin
      bad++; $display("FAIL rx_no_repeat got=%b want=0", RX_Data_Valid);
    end
    RX_Ready = 1'b0;
    tick();
  endtask

  task automatic wait_ready_after_reset(input string tag);
    int n = 0;
    while (TX_Ready !== 1'b1 && n < 2) begin
      tick();
      n++;
    end
    total++;
    if (TX_Ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready got=%b want=1", tag, TX_Ready);
    end
  endtask

  task automatic watch_quiet(input string tag);
    repeat (70) begin
      tick();
      total++;
      if (S_Data !== 1'b0 || TX_Ready !== 1'b1 || RX_Data_Valid !== 1'b0 || RX_Data !== model_word) begin
        bad++; $display("FAIL %s_quiet s=%b rdy=%b vld=%b data=%h want 0/1/0/%h",
                        tag, S_Data, TX_Ready, RX_Data_Valid, RX_Data, model_word);
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    TX_Data_Valid = 1'b1;
    repeat (5) begin
      tick();
      total++;
      if (TX_Ready !== 1'b0 || S_Data !== 1'b0 || RX_Data_Valid !== 1'b0 || RX_Data !== '0) begin
        bad++; $display("FAIL reset_state rdy=%b s=%b vld=%b data=%h want 0/0/0/0",
                        TX_Ready, S_Data, RX_Data_Valid, RX_Data);
      end
    end
    Rst = 1'b0;
    model_word = '0;
    model_full = 1'b0;
    wait_ready_after_reset("reset");
    watch_quiet("reset");
    TX_Data_Valid = 1'b0;
    tick();
  endtask

  task automatic test_small();
    send_frame(55'd3, 1'b0, 1'b0, 1'b1);
    model_word = 55'd3;
    model_full = 1'b1;
    total++;
    if (RX_Data !== 55'd3 || RX_Data_Valid !== 1'b0) begin
      bad++; $display("FAIL small_held data=%h vld=%b want 3/0", RX_Data, RX_Data_Valid);
    end
    consume();
  endtask

  task automatic test_pattern();
    send_frame(PATTERN, 1'b0, 1'b0, 1'b1);
    model_word = PATTERN;
    model_full = 1'b1;
    consume();
  endtask

  task automatic test_reset_midframe();
    TX_Data = PATTERN;
    TX_Data_Valid = 1'b1;
    tick();             // start edge k
    repeat (30) tick(); // up to k+30
    Rst = 1'b1;
    tick();
    total++;
    if (TX_Ready !== 1'b0 || S_Data !== 1'b0 || RX_Data_Valid !== 1'b0 || RX_Data !== '0) begin
      bad++; $display("FAIL midreset_state rdy=%b s=%b vld=%b data=%h want 0/0/0/0",
                      TX_Ready, S_Data, RX_Data_Valid, RX_Data);
    end
    Rst = 1'b0;
    model_word = '0;
    model_full = 1'b0;
    wait_ready_after_reset("midreset");
    watch_quiet("midreset");
    TX_Data_Valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w1, w2;
    w1 = rand_word();
    w2 = rand_word();
    RX_Ready = 1'b0;
    send_frame(w1, 1'b0, 1'b1, 1'b0);
    send_frame(w2, 1'b0, 1'b1, 1'b1);
    model_word = w2;
    model_full = 1'b1;
    repeat (3) tick();
    total++;
    if (RX_Data !== w2 || RX_Data_Valid !== 1'b0) begin
      bad++; $display("FAIL b2b_last_wins data=%h vld=%b want %h/0", RX_Data, RX_Data_Valid, w2);
    end
    consume();
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    for (int i = 0; i < 5; i++) begin
      w = rand_word();
      send_frame(w, 1'b0, 1'b1, 1'b1);
      model_word = w;
      model_full = 1'b1;
      if ($urandom_range(0, 1) == 1) consume();
    end
    if (model_full) consume();
  endtask

  initial begin
    test_reset();
    test_small();
    test_pattern();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_txrx_link.md
Name: serial_txrx_link

Overview:
- A point-to-point serial link. A transmitter and a receiver share one clock and are looped back internally over a single-wire line, `S_Data`.
- The transmitter accepts a 55-bit parallel word through a ready/valid-edge handshake. It shifts the word onto `S_Data` as a framed bit stream.
- The receiver deserializes the frame, holds the word, and presents it to the consumer under an `RX_Ready`/`RX_Data_Valid` handshake.
- `S_Data` is also brought out so the line can be observed.

Parameters:
- `DATA_W`, default 55: payload width in bits.
- `CNT_W`, default 6: bit-counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- `Clk_S`, input, 1: the single clock. All logic is on the rising edge.
- `Rst`, input, 1: synchronous, active-high reset.
- `TX_Data`, input, DATA_W: word to transmit. Sampled only on the start cycle.
- `TX_Data_Valid`, input, 1: start request. Edge-qualified.
- `TX_Ready`, output, 1: transmitter idle and able to accept a start.
- `RX_Ready`, input, 1: consumer requests the held word.
- `RX_Data_Valid`, output, 1: `RX_Data` is valid for the consumer.
- `RX_Data`, output, DATA_W: last fully received word.
- `S_Data`, output, 1: serial line, as driven by the transmitter and consumed internally by the receiver.

Behaviour:
- Reset (`Rst`=1 at a rising edge) forces:
  - `TX_Ready`=0, `S_Data`=0, `RX_Data_Valid`=0, `RX_Data`=0.
  - Both FSMs to IDLE, bit counters to 0, receiver "full" flag to 0.
  - The registered previous `TX_Data_Valid` sample (`tv_q`) to 1.
- Reset mid-frame aborts the frame. The partial word is discarded and `RX_Data` is cleared.
- All outputs are registered.

Transmitter FSM:
- IDLE
  - `TX_Ready`=1 and `S_Data`=0.
  - Start condition: `TX_Data_Valid`=1 and `tv_q`=0, i.e. a rising edge.
  - A level held high through reset or through a previous frame never starts a frame.
  - On the start edge, latch `TX_Data` into the shift register, set `TX_Ready`=0, and go to START.
- START: one cycle with `S_Data`=1 (start bit). Go to DATA.
- DATA: DATA_W cycles. `S_Data` carries bit 0 first, then 1 … 54 (LSB first). The counter runs 0..DATA_W-1. Go to STOP.
- STOP: one cycle with `S_Data`=0. Go to IDLE, with `TX_Ready`=1 on the following cycle.
- Frame timing: a start edge sampled at edge k gives:
  - start bit at k+1;
  - data bit i at k+2+i;
  - stop bit at k+57;
  - `TX_Ready`=1 from k+58.
- `tv_q` is updated every cycle. `TX_Data_Valid` is ignored outside IDLE.

Receiver FSM:
- IDLE: `S_Data`=1 sampled means a start bit. Go to RECV with counter=0.
- RECV:
  - Shift in DATA_W bits, LSB first.
  - On the edge sampling the last bit, go to LOAD.
- LOAD:
  - Copy the shift register to `RX_Data` and set full=1.
  - Go to IDLE. The stop bit (0) is ignored.
- Overrun: a new frame completing while full=1 overwrites `RX_Data`. Full stays 1; the last word wins.
- Consumer handshake:
  - `RX_Data_Valid` rises on the edge after full=1 and `RX_Ready`=1 are sampled together.
  - It stays 1 while `RX_Ready`=1.
  - When `RX_Ready` is sampled 0 while `RX_Data_Valid`=1, both `RX_Data_Valid` and full clear on that edge.
  - If `RX_Ready` drops before valid was ever asserted, full is kept.
- `RX_Data` holds its value until the next LOAD or reset. It is readable before the handshake.

Test Plan:
- Reset with `TX_Data_Valid`=1 held for 5 cycles, then release:
  - during reset: `TX_Ready`=0, `S_Data`=0, `RX_Data_Valid`=0;
  - after release with valid still high: no frame starts, `TX_Ready`=1 within 2 cycles.
- `TX_Data`=55'd3, `TX_Data_Valid` 0→1 for 4 cycles:
  - `TX_Ready`=0 within 1 cycle;
  - `S_Data` sequence is 1,1,1,0×53,0;
  - `TX_Ready`=1 at k+58;
  - `RX_Data`=3 while `RX_Data_Valid`=0.
- After that frame, raise `RX_Ready`:
  - `RX_Data_Valid`=1 on the next edge and held;
  - lowering `RX_Ready` clears it.
- `TX_Data`=55'b101101110_1110001110_101101110_1110001110_101101110_11101, same handshake:
  - `RX_Data` equals `TX_Data` bit-exact;
  - `RX_Ready` then `RX_Data_Valid` as in the previous scenario.
- Same pattern with `TX_Data_Valid` held 1 throughout, `Rst` pulsed 1 at cycle 30 of the frame:
  - on the reset edge: `TX_Ready`=0, `S_Data`=0, `RX_Data_Valid`=0, `RX_Data`=0;
  - after release with valid still high: no new frame.
- Two back-to-back frames with `RX_Ready`=0:
  - `RX_Data` shows the second word;
  - full stays set;
  - a later `RX_Ready` gives `RX_Data_Valid`=1.
